// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: control unit sequencing the multicycle RV32I datapath
// through fetch, decode, execute, memory access and write-back.
//
// Optional feature macro: MULTICYCLE_JUMP_EN (adds the JAL/JALR states).
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   opcode, funct3, zero  : instruction fields and ALU zero flag
//   mem_ready             : memory completes the current access this cycle
//   pc_hold, ir_write     : PC hold (1 = keep), instruction-register load
//   i_or_d                : memory address select (0 PC, 1 ALU out)
//   mem_read, mem_write   : memory strobes
//   reg_write             : register-file write enable
//   alu_src_a/b, alu_op   : ALU operand selects and operation
//   pc_src, mem_to_reg    : next-PC and write-back selects
//   fault                 : sticky fault code (01 illegal, 10 timeout)
//   state                 : current state encoding for debug
module multicycle_control_fsm #(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_hold,
   output logic       ir_write,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic [1:0] mem_to_reg,
   output logic [1:0] fault,
   output logic [3:0] state
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_WAIT_MAX);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXEC_R    = 4'd6,
      EXEC_I    = 4'd7,
      ALU_WB    = 4'd8,
      BRANCH    = 4'd9,
      JAL       = 4'd10,
      JALR      = 4'd11,
      ERROR     = 4'd12
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       fault_q, fault_d;
   logic             wait_st;
   logic             timeout;

   // A memory wait that has used up its budget, unless ready arrives this cycle.
   assign wait_st = (state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE);
   assign timeout = wait_st && !mem_ready && (cnt_q == WAIT_MAX);

   // State, wait counter and sticky fault registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         cnt_q   <= '0;
         fault_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_d    = state_q;
      fault_d    = fault_q;
      pc_hold    = 1'b1;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      mem_to_reg = 2'b00;

      case (state_q)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_hold   = !mem_ready;
            if (mem_ready) state_d = DECODE;
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = MEM_ADDR;
               OP_R:              state_d = EXEC_R;
               OP_I:              state_d = EXEC_I;
               OP_BR:             state_d = BRANCH;
`ifdef MULTICYCLE_JUMP_EN
               OP_JAL:            state_d = JAL;
               OP_JALR:           state_d = JALR;
`endif
               default: begin
                  state_d = ERROR;
                  fault_d = FAULT_ILLEGAL;
               end
            endcase
         end
         MEM_ADDR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
            state_d   = opcode[5] ? MEM_WRITE : MEM_READ;
         end
         MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) state_d = MEM_WB;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b01;
            state_d    = FETCH;
         end
         MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) state_d = FETCH;
         end
         EXEC_R: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            state_d   = ALU_WB;
         end
         EXEC_I: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
            state_d   = ALU_WB;
         end
         ALU_WB: begin
            reg_write = 1'b1;
            state_d   = FETCH;
         end
         BRANCH: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            if (funct3 == 3'b000 || funct3 == 3'b001) begin
               // beq takes on zero, bne on non-zero
               pc_hold = !(funct3[0] ^ zero);
               state_d = FETCH;
            end else begin
               state_d = ERROR;
               fault_d = FAULT_ILLEGAL;
            end
         end
`ifdef MULTICYCLE_JUMP_EN
         JAL: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b10;
            pc_src     = 2'b01;
            pc_hold    = 1'b0;
            state_d    = FETCH;
         end
         JALR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b10;
            pc_src     = 2'b10;
            pc_hold    = 1'b0;
            reg_write  = 1'b1;
            mem_to_reg = 2'b10;
            state_d    = FETCH;
         end
`endif
         ERROR: state_d = ERROR;
         default: begin
            state_d = ERROR;
            fault_d = FAULT_ILLEGAL;
         end
      endcase

      if (timeout) begin
         state_d = ERROR;
         fault_d = FAULT_TIMEOUT;
      end

      // Counter restarts on every state change.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (wait_st && !mem_ready) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign fault = fault_q;
   assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: expected state, control
// outputs and fault are queued as each cycle's stimulus is driven and
// compared mid-cycle by a monitor.
module tb_multicycle_control_fsm;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BAD   = 7'b1111111;

   localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1, S_MADDR = 4'd2,
                          S_MREAD = 4'd3,  S_MWB = 4'd4,    S_MWRITE = 4'd5,
                          S_EXR = 4'd6,    S_EXI = 4'd7,    S_ALUWB = 4'd8,
                          S_BR = 4'd9,     S_JAL = 4'd10,   S_JALR = 4'd11,
                          S_ERR = 4'd12;

   typedef struct packed {
      logic [3:0]  st;
      logic [15:0] outs;
      logic [1:0]  flt;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       pc_hold, ir_write, i_or_d, mem_read, mem_write, reg_write;
   logic [1:0] alu_src_a, alu_src_b, alu_op, pc_src, mem_to_reg, fault;
   logic [3:0] state;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_cyc = 0;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.MEM_WAIT_MAX(15)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
      .mem_ready(mem_ready), .pc_hold(pc_hold), .ir_write(ir_write),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .pc_src(pc_src), .mem_to_reg(mem_to_reg),
      .fault(fault), .state(state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", tag, n_cyc, got, exp);
      end
   endtask

   // Expected control vector per state, in the order
   // {pc_hold, ir_write, i_or_d, mem_read, mem_write, reg_write,
   //  alu_src_a, alu_src_b, alu_op, pc_src, mem_to_reg}.
   function automatic logic [15:0] exp_outs(input logic [3:0] st, input logic rdy,
                                            input logic [2:0] f3, input logic z);
      logic ph, irw, iod, mr, mw, rw;
      logic [1:0] a, b, op, ps, m2r;
      ph = 1'b1; irw = 1'b0; iod = 1'b0; mr = 1'b0; mw = 1'b0; rw = 1'b0;
      a = 2'b00; b = 2'b00; op = 2'b00; ps = 2'b00; m2r = 2'b00;
      case (st)
         S_FETCH:  begin mr = 1'b1; b = 2'b01; ph = !rdy; irw = rdy; end
         S_DECODE: begin a = 2'b01; b = 2'b10; end
         S_MADDR:  begin a = 2'b10; b = 2'b10; end
         S_MREAD:  begin mr = 1'b1; iod = 1'b1; end
         S_MWB:    begin rw = 1'b1; m2r = 2'b01; end
         S_MWRITE: begin mw = 1'b1; iod = 1'b1; end
         S_EXR:    begin a = 2'b10; op = 2'b10; end
         S_EXI:    begin a = 2'b10; b = 2'b10; op = 2'b10; end
         S_ALUWB:  begin rw = 1'b1; end
         S_BR: begin
            a = 2'b10; op = 2'b01; ps = 2'b01;
            if ((f3 == 3'b000 && z) || (f3 == 3'b001 && !z)) ph = 1'b0;
         end
         S_JAL:  begin rw = 1'b1; m2r = 2'b10; ps = 2'b01; ph = 1'b0; end
         S_JALR: begin a = 2'b10; b = 2'b10; ps = 2'b10; ph = 1'b0; rw = 1'b1; m2r = 2'b10; end
         default: ;
      endcase
      return {ph, irw, iod, mr, mw, rw, a, b, op, ps, m2r};
   endfunction

   // Drive one cycle of inputs (called just after a rising edge) and queue the
   // state/outputs the DUT must show in that cycle.
   task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic z,
                       input logic rdy, input logic [3:0] st, input logic [1:0] flt);
      exp_t e;
      opcode = op; funct3 = f3; zero = z; mem_ready = rdy;
      e.st = st; e.outs = exp_outs(st, rdy, f3, z); e.flt = flt;
      sb_q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check("state", 32'(state), 32'(e.st));
         check("ctrl", 32'({pc_hold, ir_write, i_or_d, mem_read, mem_write, reg_write,
                            alu_src_a, alu_src_b, alu_op, pc_src, mem_to_reg}), 32'(e.outs));
         check("fault", 32'(fault), 32'(e.flt));
         n_cyc++;
      end
   end

   initial begin
      reset = 1'b1; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // add, zero-wait
      step(OP_R, 3'd0, 1'b0, 1'b1, S_FETCH, 2'b00);
      step(OP_R, 3'd0, 1'b0, 1'b1, S_DECODE, 2'b00);
      step(OP_R, 3'd0, 1'b0, 1'b1, S_EXR, 2'b00);
      step(OP_R, 3'd0, 1'b0, 1'b1, S_ALUWB, 2'b00);
      // addi
      step(OP_I, 3'd0, 1'b0, 1'b1, S_FETCH, 2'b00);
      step(OP_I, 3'd0, 1'b0, 1'b1, S_DECODE, 2'b00);
      step(OP_I, 3'd0, 1'b0, 1'b1, S_EXI, 2'b00);
      step(OP_I, 3'd0, 1'b0, 1'b1, S_ALUWB, 2'b00);
      // load with three wait states
      step(OP_LOAD, 3'd2, 1'b0, 1'b1, S_FETCH, 2'b00);
      step(OP_LOAD, 3'd2, 1'b0, 1'b1, S_DECODE, 2'b00);
      step(OP_LOAD, 3'd2, 1'b0, 1'b1, S_MADDR, 2'b00);
      for (int i = 0; i < 3; i++) step(OP_LOAD, 3'd2, 1'b0, 1'b0, S_MREAD, 2'b00);
      step(OP_LOAD, 3'd2, 1'b0, 1'b1, S_MREAD, 2'b00);
      step(OP_LOAD, 3'd2, 1'b0, 1'b1, S_MWB, 2'b00);
      // store with one wait state
      step(OP_STORE, 3'd2, 1'b0, 1'b1, S_FETCH, 2'b00);
      step(OP_STORE, 3'd2, 1'b0, 1'b1, S_DECODE, 2'b00);
      step(OP_STORE, 3'd2, 1'b0, 1'b1, S_MADDR, 2'b00);
      step(OP_STORE, 3'd2, 1'b0, 1'b0, S_MWRITE, 2'b00);
      step(OP_STORE, 3'd2, 1'b0, 1'b1, S_MWRITE, 2'b00);
      // beq taken, bne not taken, bne taken
      step(OP_BR, 3'd0, 1'b1, 1'b1, S_FETCH, 2'b00);
      step(OP_BR, 3'd0, 1'b1, 1'b1, S_DECODE, 2'b00);
      step(OP_BR, 3'd0, 1'b1, 1'b1, S_BR, 2'b00);
      step(OP_BR, 3'd1, 1'b1, 1'b1, S_FETCH, 2'b00);
      step(OP_BR, 3'd1, 1'b1, 1'b1, S_DECODE, 2'b00);
      step(OP_BR, 3'd1, 1'b1, 1'b1, S_BR, 2'b00);
      step(OP_BR, 3'd1, 1'b0, 1'b1, S_FETCH, 2'b00);
      step(OP_BR, 3'd1, 1'b0, 1'b1, S_DECODE, 2'b00);
      step(OP_BR, 3'd1, 1'b0, 1'b1, S_BR, 2'b00);
`ifdef MULTICYCLE_JUMP_EN
      step(OP_JAL, 3'd0, 1'b0, 1'b1, S_FETCH, 2'b00);
      step(OP_JAL, 3'd0, 1'b0, 1'b1, S_DECODE, 2'b00);
      step(OP_JAL, 3'd0, 1'b0, 1'b1, S_JAL, 2'b00);
      step(OP_JALR, 3'd0, 1'b0, 1'b1, S_FETCH, 2'b00);
      step(OP_JALR, 3'd0, 1'b0, 1'b1, S_DECODE, 2'b00);
      step(OP_JALR, 3'd0, 1'b0, 1'b1, S_JALR, 2'b00);
      step(OP_R, 3'd0, 1'b0, 1'b1, S_FETCH, 2'b00);
`else
      step(OP_JAL, 3'd0, 1'b0, 1'b1, S_FETCH, 2'b00);
      step(OP_JAL, 3'd0, 1'b0, 1'b1, S_DECODE, 2'b00);
      step(OP_JAL, 3'd0, 1'b0, 1'b1, S_ERR, 2'b01);
      do_reset();
      step(OP_JALR, 3'd0, 1'b0, 1'b1, S_FETCH, 2'b00);
      step(OP_JALR, 3'd0, 1'b0, 1'b1, S_DECODE, 2'b00);
      step(OP_JALR, 3'd0, 1'b0, 1'b1, S_ERR, 2'b01);
      do_reset();
      step(OP_R, 3'd0, 1'b0, 1'b1, S_FETCH, 2'b00);
`endif
      // illegal branch funct3
      step(OP_BR, 3'd2, 1'b0, 1'b1, S_DECODE, 2'b00);
      step(OP_BR, 3'd2, 1'b0, 1'b1, S_BR, 2'b00);
      step(OP_R, 3'd0, 1'b0, 1'b1, S_ERR, 2'b01);
      step(OP_R, 3'd0, 1'b0, 1'b0, S_ERR, 2'b01);
      do_reset();
      // illegal opcode, sticky through later stimulus
      step(OP_BAD, 3'd0, 1'b0, 1'b1, S_FETCH, 2'b00);
      step(OP_BAD, 3'd0, 1'b0, 1'b1, S_DECODE, 2'b00);
      for (int i = 0; i < 3; i++) step(OP_R, 3'd0, 1'b1, 1'b1, S_ERR, 2'b01);
      do_reset();
      // fetch timeout: 16th not-ready cycle faults
      for (int i = 0; i < 16; i++) step(OP_R, 3'd0, 1'b0, 1'b0, S_FETCH, 2'b00);
      step(OP_R, 3'd0, 1'b0, 1'b1, S_ERR, 2'b10);
      step(OP_R, 3'd0, 1'b0, 1'b1, S_ERR, 2'b10);
      do_reset();
      // ready on the last allowed cycle wins
      for (int i = 0; i < 15; i++) step(OP_R, 3'd0, 1'b0, 1'b0, S_FETCH, 2'b00);
      step(OP_R, 3'd0, 1'b0, 1'b1, S_FETCH, 2'b00);
      step(OP_R, 3'd0, 1'b0, 1'b1, S_DECODE, 2'b00);
      step(OP_R, 3'd0, 1'b0, 1'b1, S_EXR, 2'b00);
      step(OP_R, 3'd0, 1'b0, 1'b1, S_ALUWB, 2'b00);
      // MEM_READ timeout after a restarted counter
      step(OP_LOAD, 3'd2, 1'b0, 1'b0, S_FETCH, 2'b00);
      step(OP_LOAD, 3'd2, 1'b0, 1'b1, S_FETCH, 2'b00);
      step(OP_LOAD, 3'd2, 1'b0, 1'b1, S_DECODE, 2'b00);
      step(OP_LOAD, 3'd2, 1'b0, 1'b1, S_MADDR, 2'b00);
      for (int i = 0; i < 16; i++) step(OP_LOAD, 3'd2, 1'b0, 1'b0, S_MREAD, 2'b00);
      step(OP_LOAD, 3'd2, 1'b0, 1'b1, S_ERR, 2'b10);
      do_reset();
      // reset aborts an access mid-wait
      step(OP_LOAD, 3'd2, 1'b0, 1'b1, S_FETCH, 2'b00);
      step(OP_LOAD, 3'd2, 1'b0, 1'b1, S_DECODE, 2'b00);
      step(OP_LOAD, 3'd2, 1'b0, 1'b1, S_MADDR, 2'b00);
      step(OP_LOAD, 3'd2, 1'b0, 1'b0, S_MREAD, 2'b00);
      do_reset();
      step(OP_LOAD, 3'd2, 1'b0, 1'b0, S_FETCH, 2'b00);
      step(OP_LOAD, 3'd2, 1'b0, 1'b1, S_FETCH, 2'b00);
      // reset beats a pending illegal-opcode fault on the same edge
      opcode = OP_BAD; mem_ready = 1'b1;
      do_reset();
      step(OP_BAD, 3'd0, 1'b0, 1'b1, S_FETCH, 2'b00);

      @(negedge clk); #1;
      if (sb_q.size() != 0) check("drain", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
